// File: rtl/led_driver.sv
// Multi-channel LED driver: per-channel off / on / blink / breathe, sharing one tick prescaler and PWM counter.
// Define LED_DRIVER_BREATHE_EN to build mode 3 (breathe); without it mode 3 behaves as off.
module led_driver #(
    parameter int  TICK_DIV = 100_000,
    parameter int  NCHAN    = 2,
    parameter int  PER_W    = 10,
    parameter int  PWM_W    = 8,
    localparam int CH_W     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             sysClk,
    input  logic             rst,
    input  logic             wrEn,
    input  logic [CH_W-1:0]  wrChan,
    input  logic [1:0]       wrMode,
    input  logic [PER_W-1:0] wrArg,
    output logic [NCHAN-1:0] led,
    output logic             tick
);
    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 1);

`ifdef LED_DRIVER_BREATHE_EN
    localparam bit BREATHE_EN = 1'b1;
`else
    localparam bit BREATHE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    logic [CNT_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic [PWM_W-1:0] pwm_q, pwm_d;

    always_comb begin
        pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        tick_d = (pre_q == PRE_LAST);
        pwm_d  = pwm_q + 1'b1;
    end

    always_ff @(posedge sysClk) begin
        if (rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            pwm_q  <= '0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            pwm_q  <= pwm_d;
        end
    end

    assign tick = tick_q;

`ifndef LED_DRIVER_BREATHE_EN
    logic unused_pwm;
    assign unused_pwm = ^pwm_q;
`endif

    genvar gi;
    for (gi = 0; gi < NCHAN; gi++) begin : g_chan
        localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);

        mode_e            mode_q, mode_d;
        logic [PER_W-1:0] arg_q, arg_d;
        logic [PER_W-1:0] phase_q, phase_d;
        logic             blink_q, blink_d;
        logic             led_q, led_d;
        logic             wr_hit;
        logic             advance;
        logic             period_end;
        logic [PER_W-1:0] last_phase;
        logic             breathe_led;

        // Out-of-range channel numbers simply never match any channel.
        assign wr_hit     = wrEn && (wrChan == CH_IDX);
        assign last_phase = (arg_q == '0) ? '0 : arg_q - 1'b1;
        assign advance    = tick_q && ((mode_q == MODE_BLINK) ||
                                       (BREATHE_EN && (mode_q == MODE_BREATHE)));
        assign period_end = advance && (phase_q == last_phase);

        always_comb begin
            mode_d  = mode_q;
            arg_d   = arg_q;
            phase_d = phase_q;
            blink_d = blink_q;
            if (wr_hit) begin
                mode_d  = mode_e'(wrMode);
                arg_d   = wrArg;
                phase_d = '0;
                blink_d = 1'b1;
            end else if (period_end) begin
                phase_d = '0;
                blink_d = (mode_q == MODE_BLINK) ? ~blink_q : blink_q;
            end else if (advance) begin
                phase_d = phase_q + 1'b1;
            end
        end

`ifdef LED_DRIVER_BREATHE_EN
        localparam logic [PWM_W-1:0] DUTY_TOP = '1;

        logic [PWM_W-1:0] duty_q, duty_d;
        logic             fall_q, fall_d;

        // Triangle ramp: saturate at both ends by flipping direction on arrival.
        always_comb begin
            duty_d = duty_q;
            fall_d = fall_q;
            if (wr_hit) begin
                duty_d = '0;
                fall_d = 1'b0;
            end else if ((mode_q == MODE_BREATHE) && period_end) begin
                if (!fall_q) begin
                    duty_d = duty_q + 1'b1;
                    fall_d = (duty_q == DUTY_TOP - 1'b1);
                end else begin
                    duty_d = duty_q - 1'b1;
                    fall_d = (duty_q != PWM_W'(1));
                end
            end
        end

        always_ff @(posedge sysClk) begin
            if (rst) begin
                duty_q <= '0;
                fall_q <= 1'b0;
            end else begin
                duty_q <= duty_d;
                fall_q <= fall_d;
            end
        end

        assign breathe_led = (pwm_q < duty_q);
`else
        assign breathe_led = 1'b0;
`endif

        always_comb begin
            led_d = 1'b0;
            case (mode_q)
                MODE_ON:      led_d = 1'b1;
                MODE_BLINK:   led_d = blink_q;
                MODE_BREATHE: led_d = breathe_led;
                default:      led_d = 1'b0;
            endcase
        end

        always_ff @(posedge sysClk) begin
            if (rst) begin
                mode_q  <= MODE_OFF;
                arg_q   <= '0;
                phase_q <= '0;
                blink_q <= 1'b0;
                led_q   <= 1'b0;
            end else begin
                mode_q  <= mode_d;
                arg_q   <= arg_d;
                phase_q <= phase_d;
                blink_q <= blink_d;
                led_q   <= led_d;
            end
        end

        assign led[gi] = led_q;
    end

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: vector table, hand-written timing sequences,
// and random writes checked cycle-by-cycle against a behavioural model.
module tb_led_driver;
    localparam int TICK_DIV = 4;
    localparam int NCHAN    = 3;
    localparam int PER_W    = 4;
    localparam int PWM_W    = 4;
    localparam int DMAX     = (1 << PWM_W) - 1;

    logic             sysClk = 1'b0;
    logic             rst    = 1'b1;
    logic             wrEn   = 1'b0;
    logic [1:0]       wrChan = '0;
    logic [1:0]       wrMode = '0;
    logic [PER_W-1:0] wrArg  = '0;
    logic [NCHAN-1:0] led;
    logic             tick;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 sysClk = ~sysClk;

    led_driver #(
        .TICK_DIV(TICK_DIV),
        .NCHAN   (NCHAN),
        .PER_W   (PER_W),
        .PWM_W   (PWM_W)
    ) dut (
        .sysClk(sysClk),
        .rst   (rst),
        .wrEn  (wrEn),
        .wrChan(wrChan),
        .wrMode(wrMode),
        .wrArg (wrArg),
        .led   (led),
        .tick  (tick)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: each channel remembers its mode/arg and how many ticks it has
    // seen since its last write; the LED value follows from that count arithmetically.
    int               m_mode[NCHAN];
    int               m_arg[NCHAN];
    int               m_k[NCHAN];
    int               m_edges;
    logic [NCHAN-1:0] m_led;
    logic [NCHAN-1:0] m_nl;
    logic             m_tick;

    function automatic logic model_led(input int mode, input int arg, input int k, input int pwm);
        int h;
        int s;
        int p;
        int d;
        h = (arg == 0) ? 1 : arg;
        s = k / h;
        p = s % (2 * DMAX);
        d = (p <= DMAX) ? p : (2 * DMAX - p);
        case (mode)
            1: return 1'b1;
            2: return ((s % 2) == 0);
`ifdef LED_DRIVER_BREATHE_EN
            3: return (pwm < d);
`endif
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge sysClk) begin
        if (rst) begin
            for (int c = 0; c < NCHAN; c++) begin
                m_mode[c] = 0;
                m_arg[c]  = 0;
                m_k[c]    = 0;
            end
            m_edges = 0;
            m_led   = '0;
            m_tick  = 1'b0;
        end else begin
            for (int c = 0; c < NCHAN; c++)
                m_nl[c] = model_led(m_mode[c], m_arg[c], m_k[c], m_edges % (DMAX + 1));
            for (int c = 0; c < NCHAN; c++) begin
                if (wrEn && (int'(wrChan) == c)) begin
                    m_mode[c] = int'(wrMode);
                    m_arg[c]  = int'(wrArg);
                    m_k[c]    = 0;
                end else if (m_tick) begin
                    m_k[c]++;
                end
            end
            m_edges++;
            m_led  = m_nl;
            m_tick = ((m_edges % TICK_DIV) == 0);
        end
    end

    always @(negedge sysClk) begin
        if (chk_en && errors < 100) begin
            check("model_led", int'(led), int'(m_led));
            check("model_tick", int'(tick), int'(m_tick));
        end
    end

    // Called at a negedge; the write is taken on the following posedge.
    task automatic do_write(input logic [1:0] ch, input logic [1:0] mode, input logic [PER_W-1:0] arg);
        wrEn   = 1'b1;
        wrChan = ch;
        wrMode = mode;
        wrArg  = arg;
        @(negedge sysClk);
        wrEn   = 1'b0;
    endtask

    task automatic wait_tick(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge sysClk);
            if (tick) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic wait_change(input int idx, input int bound, output int n);
        logic prev;
        prev = led[idx];
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge sysClk);
            if (led[idx] !== prev) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic clear_all();
        for (int c = 0; c < NCHAN; c++) do_write(2'(c), 2'd0, '0);
        @(negedge sysClk);
        @(negedge sysClk);
        check("clear_all", int'(led), 0);
    endtask

    typedef struct {
        logic [1:0]       ch;
        logic [1:0]       mode;
        logic [PER_W-1:0] arg;
        logic [NCHAN-1:0] exp1;
        logic [NCHAN-1:0] exp2;
    } vec_t;

    initial begin
        vec_t vt[10];
        int   n;
        int   cnt;
        int   highs;
        int   peak;
        int   sum;
        logic ring[16];

        vt[0] = '{2'd2, 2'd1, 4'd0,  3'b000, 3'b100};
        vt[1] = '{2'd3, 2'd1, 4'd0,  3'b100, 3'b100};
        vt[2] = '{2'd0, 2'd1, 4'd0,  3'b100, 3'b101};
        vt[3] = '{2'd1, 2'd2, 4'd15, 3'b101, 3'b111};
        vt[4] = '{2'd2, 2'd0, 4'd0,  3'b111, 3'b011};
        vt[5] = '{2'd3, 2'd0, 4'd0,  3'b011, 3'b011};
        vt[6] = '{2'd0, 2'd0, 4'd0,  3'b011, 3'b010};
        vt[7] = '{2'd1, 2'd0, 4'd0,  3'b010, 3'b000};
        vt[8] = '{2'd1, 2'd1, 4'd0,  3'b000, 3'b010};
        vt[9] = '{2'd0, 2'd3, 4'd0,  3'b010, 3'b010};

        // Reset held three cycles, then tick cadence with no writes.
        rst = 1'b1;
        repeat (3) @(posedge sysClk);
        @(negedge sysClk);
        chk_en = 1'b1;
        check("reset_led", int'(led), 0);
        check("reset_tick", int'(tick), 0);
        rst = 1'b0;
        wait_tick(8, n);
        check("tick_first", n, TICK_DIV);
        for (int p = 0; p < 3; p++) begin
            cnt = 0;
            for (int j = 0; j < TICK_DIV - 1; j++) begin
                @(negedge sysClk);
                cnt += int'(tick);
            end
            check("tick_gap", cnt, 0);
            @(negedge sysClk);
            check("tick_pulse", int'(tick), 1);
        end
        check("idle_led", int'(led), 0);

        // Vector table: write, then LED one edge later (unchanged) and two edges later.
        for (int i = 0; i < 10; i++) begin
            do_write(vt[i].ch, vt[i].mode, vt[i].arg);
            check($sformatf("vec%0d_edge1", i), int'(led), int'(vt[i].exp1));
            @(negedge sysClk);
            check($sformatf("vec%0d_edge2", i), int'(led), int'(vt[i].exp2));
        end
        clear_all();

        // Blink arg=2: lights two edges after the write, then 8-cycle toggles.
        do_write(2'd1, 2'd2, 4'd2);
        check("blink2_edge1", int'(led[1]), 0);
        @(negedge sysClk);
        check("blink2_edge2", int'(led[1]), 1);
        wait_change(1, 20, n);
        check("blink2_first_toggle", int'(n > 0), 1);
        for (int j = 0; j < 2; j++) begin
            wait_change(1, 20, n);
            check("blink2_interval", n, 2 * TICK_DIV);
        end
        check("blink2_others", int'({led[2], led[0]}), 0);

        // Blink arg=0 behaves as arg=1: toggle every tick.
        do_write(2'd1, 2'd2, 4'd0);
        @(negedge sysClk);
        check("blink0_edge2", int'(led[1]), 1);
        wait_change(1, 10, n);
        check("blink0_first_toggle", int'(n > 0), 1);
        for (int j = 0; j < 2; j++) begin
            wait_change(1, 10, n);
            check("blink0_interval", n, TICK_DIV);
        end

        // OFF written in the tick cycle: no further toggles.
        wait_tick(8, n);
        check("sync_tick_found", int'(n > 0), 1);
        do_write(2'd1, 2'd0, 4'd0);
        @(negedge sysClk);
        check("off_on_tick", int'(led[1]), 0);
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge sysClk);
            cnt += int'(led[1]);
        end
        check("off_stays_low", cnt, 0);

        // Out-of-range write, then ch2 ON held for 100 cycles.
        do_write(2'd3, 2'd1, 4'd0);
        @(negedge sysClk);
        check("oor_ignored", int'(led), 0);
        do_write(2'd2, 2'd1, 4'd0);
        @(negedge sysClk);
        check("ch2_on", int'(led[2]), 1);
        cnt = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge sysClk);
            cnt += int'(!led[2]);
        end
        check("ch2_on_held", cnt, 0);

        // Reset in the middle of a blink.
        do_write(2'd1, 2'd2, 4'd1);
        repeat (10) @(negedge sysClk);
        rst = 1'b1;
        @(negedge sysClk);
        check("midreset_led", int'(led), 0);
        check("midreset_tick", int'(tick), 0);
        rst = 1'b0;
        repeat (12) @(negedge sysClk);
        check("post_reset_led", int'(led), 0);

        // Breathe on ch0, arg=1.
        do_write(2'd0, 2'd3, 4'd1);
        highs = 0;
        peak  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sysClk);
            highs += int'(led[0]);
            ring[i % 16] = led[0];
            if (i >= 15) begin
                sum = 0;
                for (int j = 0; j < 16; j++) sum += int'(ring[j]);
                if (sum > peak) peak = sum;
            end
        end
`ifdef LED_DRIVER_BREATHE_EN
        check("breathe_active", int'(highs > 0), 1);
        check("breathe_peak_ge12", int'(peak >= 12), 1);
        check("breathe_peak_le15", int'(peak <= DMAX), 1);
`else
        check("breathe_off", highs, 0);
`endif
        clear_all();

        // Random writes, model compares every cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                wrEn   = 1'b1;
                wrChan = 2'($urandom_range(0, 3));
                wrMode = 2'($urandom_range(0, 3));
                wrArg  = PER_W'($urandom_range(0, 15));
            end else begin
                wrEn = 1'b0;
            end
            @(negedge sysClk);
        end
        wrEn = 1'b0;
        @(negedge sysClk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
